// File: rtl/ifu_fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface ifu_fetch_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;

    // Fetch stage side: issues requests, consumes responses.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    // Memory side: accepts requests, returns responses.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/ifu_fetch_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, keeps one imem fetch
// outstanding, buffers a response that arrives during a stall, and honours
// EXE redirects without losing or duplicating instructions.
module ifu_fetch_stage #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          INST_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_enable,
    input  logic                if_id_enable,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    ifu_fetch_stage_if.master   imem,
    output logic                if_id_valid,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic [INST_W-1:0]   if_id_inst,
    output logic [4:0]          if_id_rs1,
    output logic [4:0]          if_id_rs2
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] buf_q, buf_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
    logic [INST_W-1:0] if_id_inst_q, if_id_inst_d;

    logic              accept;
    logic              deliver;
    logic [INST_W-1:0] deliver_inst;

    assign accept = pc_enable & if_id_enable;

    // State register: FSM, PC, stall buffer and IF/ID fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            buf_q         <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_q         <= buf_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
        end
    end

    // Next-state: fetch FSM, PC update and IF/ID load with flush-over-stall priority.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        deliver       = 1'b0;
        deliver_inst  = buf_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;

        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (imem.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    // A response landing with the redirect belongs to the old path: drop it.
                    pc_d    = redirect_pc;
                    state_d = imem.imem_resp_valid ? S_REQ : S_DRAIN;
                end else if (imem.imem_resp_valid) begin
                    if (accept) begin
                        deliver      = 1'b1;
                        deliver_inst = imem.imem_resp_data;
                        pc_d         = pc_q + ADDR_W'(4);
                        state_d      = S_REQ;
                    end else begin
                        buf_d   = imem.imem_resp_data;
                        state_d = S_HOLD;
                    end
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem.imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (accept) begin
                    deliver      = 1'b1;
                    deliver_inst = buf_q;
                    pc_d         = pc_q + ADDR_W'(4);
                    state_d      = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            if_id_valid_d = 1'b0;
        end else if (accept) begin
            if (deliver) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = pc_q;
                if_id_inst_d  = deliver_inst;
            end else begin
                if_id_valid_d = 1'b0;
            end
        end
    end

    // Outputs: request only from REQ, suppressed by a same-cycle redirect and by reset.
    always_comb begin
        imem.imem_req_valid = rst_n & (state_q == S_REQ) & ~redirect_valid;
        imem.imem_req_addr  = pc_q;
        if_id_valid         = if_id_valid_q;
        if_id_pc            = if_id_pc_q;
        if_id_inst          = if_id_inst_q;
        if_id_rs1           = if_id_inst_q[19:15];
        if_id_rs2           = if_id_inst_q[24:20];
    end

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Directed self-checking bench for ifu_fetch_stage.
module tb_ifu_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_enable;
    logic        if_id_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;

    int tests;
    int fails;

    ifu_fetch_stage_if #(.ADDR_W(32), .INST_W(32)) imem ();

    ifu_fetch_stage #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_enable      (pc_enable),
        .if_id_enable   (if_id_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_inst     (if_id_inst),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_accept(input logic a);
        pc_enable    = a;
        if_id_enable = a;
    endtask

    task automatic test_reset();
        rst_n                = 1'b0;
        set_accept(1'b1);
        redirect_valid       = 1'b0;
        redirect_pc          = '0;
        imem.imem_req_ready  = 1'b0;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = '0;
        tick();
        tick();
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
        tests++; if (if_id_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected 00000000", if_id_pc); end
        tests++; if (if_id_inst !== 32'h0 || if_id_rs1 !== 5'd0 || if_id_rs2 !== 5'd0) begin
            fails++; $display("FAIL reset_inst: got %h/%0d/%0d expected 0/0/0", if_id_inst, if_id_rs1, if_id_rs2); end
        tests++; if (imem.imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b expected 0", imem.imem_req_valid); end
        rst_n = 1'b1;
        #1;
        tests++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h8000_0000) begin
            fails++; $display("FAIL first_req: got %b/%h expected 1/80000000", imem.imem_req_valid, imem.imem_req_addr); end
    endtask

    // Three back-to-back fetches, one response per request, accept held high.
    task automatic test_sequential();
        logic [31:0] data [3];
        data[0] = 32'h00A5_8533;
        data[1] = 32'h1234_5678;
        data[2] = 32'hCAFE_F00D;
        imem.imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h8000_0000 + 32'(4 * i)) begin
                fails++; $display("FAIL seq_req[%0d]: got %b/%h expected 1/%h", i, imem.imem_req_valid, imem.imem_req_addr, 32'h8000_0000 + 32'(4 * i)); end
            tick();
            tests++; if (imem.imem_req_valid !== 1'b0 || if_id_valid !== 1'b0) begin
                fails++; $display("FAIL seq_wait[%0d]: req_valid %b if_id_valid %b expected 0/0", i, imem.imem_req_valid, if_id_valid); end
            imem.imem_resp_valid = 1'b1;
            imem.imem_resp_data  = data[i];
            tick();
            imem.imem_resp_valid = 1'b0;
            tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8000_0000 + 32'(4 * i) || if_id_inst !== data[i]) begin
                fails++; $display("FAIL seq_ifid[%0d]: got %b/%h/%h expected 1/%h/%h", i, if_id_valid, if_id_pc, if_id_inst, 32'h8000_0000 + 32'(4 * i), data[i]); end
            if (i == 0) begin
                tests++; if (if_id_rs1 !== 5'd11 || if_id_rs2 !== 5'd10) begin
                    fails++; $display("FAIL seq_rs: got rs1=%0d rs2=%0d expected 11/10", if_id_rs1, if_id_rs2); end
            end
        end
    endtask

    // Response arrives during a 2-cycle stall; buffered instruction delivered exactly once.
    task automatic test_hold();
        set_accept(1'b0);
        imem.imem_req_ready = 1'b1;
        tick();
        imem.imem_req_ready  = 1'b0;
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem.imem_resp_valid = 1'b0;
        tick();
        tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8000_0008 || if_id_inst !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL hold_ifid: got %b/%h/%h expected 1/80000008/cafef00d", if_id_valid, if_id_pc, if_id_inst); end
        tests++; if (imem.imem_req_valid !== 1'b0) begin fails++; $display("FAIL hold_req_valid: got %b expected 0", imem.imem_req_valid); end
        set_accept(1'b1);
        tick();
        tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8000_000C || if_id_inst !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL hold_release: got %b/%h/%h expected 1/8000000c/deadbeef", if_id_valid, if_id_pc, if_id_inst); end
        tests++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h8000_0010) begin
            fails++; $display("FAIL hold_next_req: got %b/%h expected 1/80000010", imem.imem_req_valid, imem.imem_req_addr); end
        tick();
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL hold_once: got %b expected 0", if_id_valid); end
    endtask

    // Redirect while waiting with no response: late response discarded.
    task automatic test_redirect_drain();
        imem.imem_req_ready = 1'b1;
        tick();
        imem.imem_req_ready = 1'b0;
        redirect_valid      = 1'b1;
        redirect_pc         = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        #1;
        tests++; if (imem.imem_req_valid !== 1'b0 || if_id_valid !== 1'b0) begin
            fails++; $display("FAIL drain_state: req_valid %b if_id_valid %b expected 0/0", imem.imem_req_valid, if_id_valid); end
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = 32'hBAD0_0000;
        tick();
        imem.imem_resp_valid = 1'b0;
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL drain_discard: got %b expected 0", if_id_valid); end
        tests++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h8000_0100) begin
            fails++; $display("FAIL drain_refetch: got %b/%h expected 1/80000100", imem.imem_req_valid, imem.imem_req_addr); end
        imem.imem_req_ready = 1'b1;
        tick();
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = 32'h1111_1111;
        tick();
        imem.imem_resp_valid = 1'b0;
        tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8000_0100 || if_id_inst !== 32'h1111_1111) begin
            fails++; $display("FAIL drain_target: got %b/%h/%h expected 1/80000100/11111111", if_id_valid, if_id_pc, if_id_inst); end
    endtask

    // Redirect coinciding with a stall: flush wins, PC takes target.
    task automatic test_redirect_stall();
        set_accept(1'b0);
        imem.imem_req_ready = 1'b1;
        redirect_valid      = 1'b1;
        redirect_pc         = 32'h8000_0200;
        #1;
        tests++; if (imem.imem_req_valid !== 1'b0) begin fails++; $display("FAIL rs_req_suppressed: got %b expected 0", imem.imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        imem.imem_req_ready = 1'b0;
        set_accept(1'b1);
        #1;
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL rs_flush: got %b expected 0", if_id_valid); end
        tests++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h8000_0200) begin
            fails++; $display("FAIL rs_pc: got %b/%h expected 1/80000200", imem.imem_req_valid, imem.imem_req_addr); end
    endtask

    // Memory back-pressure: request held stable until accepted.
    task automatic test_ready_stall();
        imem.imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h8000_0200) begin
                fails++; $display("FAIL ready_stall[%0d]: got %b/%h expected 1/80000200", i, imem.imem_req_valid, imem.imem_req_addr); end
        end
        imem.imem_req_ready = 1'b1;
        tick();
        tests++; if (imem.imem_req_valid !== 1'b0) begin fails++; $display("FAIL ready_accept: got %b expected 0", imem.imem_req_valid); end
        imem.imem_req_ready  = 1'b0;
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = 32'h2222_2222;
        tick();
        imem.imem_resp_valid = 1'b0;
        tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8000_0200 || if_id_inst !== 32'h2222_2222) begin
            fails++; $display("FAIL ready_deliver: got %b/%h/%h expected 1/80000200/22222222", if_id_valid, if_id_pc, if_id_inst); end
    endtask

    // Asynchronous reset while a fetch is outstanding.
    task automatic test_reset_mid();
        set_accept(1'b0);
        imem.imem_req_ready = 1'b1;
        tick();
        imem.imem_req_ready = 1'b0;
        tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL rm_pre: got %b expected 1", if_id_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (if_id_valid !== 1'b0 || imem.imem_req_valid !== 1'b0 || if_id_inst !== 32'h0) begin
            fails++; $display("FAIL rm_async: got %b/%b/%h expected 0/0/00000000", if_id_valid, imem.imem_req_valid, if_id_inst); end
        set_accept(1'b1);
        tick();
        rst_n = 1'b1;
        #1;
        tests++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h8000_0000) begin
            fails++; $display("FAIL rm_restart: got %b/%h expected 1/80000000", imem.imem_req_valid, imem.imem_req_addr); end
    endtask

    // PC wrap, stray response in REQ, and redirect colliding with a response.
    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid      = 1'b0;
        imem.imem_req_ready = 1'b1;
        tick();
        imem.imem_req_ready  = 1'b0;
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = 32'h3333_3333;
        tick();
        imem.imem_resp_valid = 1'b0;
        tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC || if_id_inst !== 32'h3333_3333) begin
            fails++; $display("FAIL wrap_ifid: got %b/%h/%h expected 1/fffffffc/33333333", if_id_valid, if_id_pc, if_id_inst); end
        tests++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h0) begin
            fails++; $display("FAIL wrap_addr: got %b/%h expected 1/00000000", imem.imem_req_valid, imem.imem_req_addr); end
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = 32'h5555_5555;
        tick();
        imem.imem_resp_valid = 1'b0;
        tests++; if (if_id_valid !== 1'b0 || imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h0) begin
            fails++; $display("FAIL stray_resp: got %b/%b/%h expected 0/1/00000000", if_id_valid, imem.imem_req_valid, imem.imem_req_addr); end
        imem.imem_req_ready = 1'b1;
        tick();
        imem.imem_req_ready  = 1'b0;
        redirect_valid       = 1'b1;
        redirect_pc          = 32'h8000_0300;
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = 32'h4444_4444;
        tick();
        redirect_valid       = 1'b0;
        imem.imem_resp_valid = 1'b0;
        #1;
        tests++; if (if_id_valid !== 1'b0 || imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h8000_0300) begin
            fails++; $display("FAIL redir_resp: got %b/%b/%h expected 0/1/80000300", if_id_valid, imem.imem_req_valid, imem.imem_req_addr); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_sequential();
        test_hold();
        test_redirect_drain();
        test_redirect_stall();
        test_ready_stall();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
